// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: sequencer state codes, opcodes, jump conditions,
// address-mux encodings and the registered strobe bundle driven by the execution block.
package cpu_pkg;

   localparam logic [7:0] STATE_NEXT       = 8'h00;
   localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
   localparam logic [7:0] STATE_FETCH_INST = 8'h02;
   localparam logic [7:0] STATE_HALT       = 8'h03;
   localparam logic [7:0] STATE_JUMP       = 8'h04;
   localparam logic [7:0] STATE_OUT        = 8'h05;
   localparam logic [7:0] STATE_ALU_OUT    = 8'h06;
   localparam logic [7:0] STATE_ALU_EXEC   = 8'h07;
   localparam logic [7:0] STATE_MOV_STORE  = 8'h08;
   localparam logic [7:0] STATE_MOV_FETCH  = 8'h09;
   localparam logic [7:0] STATE_MOV_LOAD   = 8'h0A;
   localparam logic [7:0] STATE_FETCH_SP   = 8'h0C;
   localparam logic [7:0] STATE_PC_STORE   = 8'h0D;
   localparam logic [7:0] STATE_TMP_JUMP   = 8'h0E;
   localparam logic [7:0] STATE_RET        = 8'h0F;
   localparam logic [7:0] STATE_INC_SP     = 8'h10;
   localparam logic [7:0] STATE_SET_ADDR   = 8'h11;
   localparam logic [7:0] STATE_IN         = 8'h12;
   localparam logic [7:0] STATE_REG_STORE  = 8'h13;
   localparam logic [7:0] STATE_SET_REG    = 8'h14;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_HLT  = 8'h01;
   localparam logic [7:0] OP_JMP  = 8'h02;
   localparam logic [7:0] OP_CALL = 8'h03;
   localparam logic [7:0] OP_RET  = 8'h04;
   localparam logic [7:0] OP_PUSH = 8'h05;
   localparam logic [7:0] OP_POP  = 8'h06;
   localparam logic [7:0] OP_MOV  = 8'h07;
   localparam logic [7:0] OP_LDI  = 8'h08;
   localparam logic [7:0] OP_ALU  = 8'h09;
   localparam logic [7:0] OP_CMP  = 8'h0A;
   localparam logic [7:0] OP_IN   = 8'h0B;
   localparam logic [7:0] OP_OUT  = 8'h0C;

   localparam logic [2:0] JC_ALWAYS = 3'd0;
   localparam logic [2:0] JC_Z      = 3'd1;
   localparam logic [2:0] JC_NZ     = 3'd2;
   localparam logic [2:0] JC_C      = 3'd3;
   localparam logic [2:0] JC_NC     = 3'd4;

   localparam logic [1:0] ADDR_PC  = 2'd0;
   localparam logic [1:0] ADDR_SP  = 2'd1;
   localparam logic [1:0] ADDR_TMP = 2'd2;

   typedef struct packed {
      logic [1:0] addr_sel;
      logic       mem_rd;
      logic       mem_wr;
      logic       io_rd;
      logic       io_wr;
      logic       pc_inc;
      logic       pc_load;
      logic       ir_load;
      logic       tmp_load;
      logic       reg_we;
      logic [2:0] reg_sel;
      logic       pc_to_bus;
      logic       alu_en;
      logic [2:0] alu_op;
      logic       bad_state;
   } ctrl_t;

   localparam int    CTRL_W    = $bits(ctrl_t);
   localparam ctrl_t CTRL_IDLE = ctrl_t'({CTRL_W{1'b0}});

   // flags is {C,Z}; unknown condition codes never jump
   function automatic logic jump_taken(input logic [2:0] cond, input logic [1:0] flags);
      logic taken;
      case (cond)
         JC_ALWAYS: taken = 1'b1;
         JC_Z:      taken = flags[0];
         JC_NZ:     taken = ~flags[0];
         JC_C:      taken = flags[1];
         JC_NC:     taken = ~flags[1];
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cpu_sp_reg.sv
// 8-bit downward-growing stack pointer; wraps modulo 256, holds while frozen.
module cpu_sp_reg
   import cpu_pkg::*;
#(
   parameter logic [7:0] SP_RESET = 8'hFF
) (
   input  logic       clk,
   input  logic       reset_cycle,
   input  logic       inc,
   input  logic       dec,
   input  logic       freeze,
   output logic [7:0] sp
);

   logic [7:0] sp_r;

   // stack pointer register
   always_ff @(posedge clk or posedge reset_cycle) begin
      if (reset_cycle) begin
         sp_r <= SP_RESET;
      end else if (freeze) begin
         sp_r <= sp_r;
      end else if (inc) begin
         sp_r <= sp_r + 8'd1;
      end else if (dec) begin
         sp_r <= sp_r - 8'd1;
      end else begin
         sp_r <= sp_r;
      end
   end

   assign sp = sp_r;

endmodule

// File: rtl/cpu_ctrl_exec.sv
// Execution side of the CPU control path: decodes the sequencer state into registered
// datapath strobes and owns the stack pointer, the {C,Z} flags and the halt latch.
module cpu_ctrl_exec
   import cpu_pkg::*;
#(
   parameter logic [7:0] SP_RESET = 8'hFF,
   parameter logic [2:0] MEM_REG  = 3'd7
) (
   input  logic       clk,
   input  logic       reset_cycle,
   input  logic [7:0] state,
   input  logic [7:0] opcode,
   input  logic [7:0] instruction,
   input  logic       alu_z,
   input  logic       alu_c,
   output logic [1:0] addr_sel,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       io_rd,
   output logic       io_wr,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       ir_load,
   output logic       tmp_load,
   output logic       reg_we,
   output logic [2:0] reg_sel,
   output logic       pc_to_bus,
   output logic       alu_en,
   output logic [2:0] alu_op,
   output logic [7:0] sp,
   output logic [1:0] flags,
   output logic       halted,
   output logic       bad_state
);

   ctrl_t      ctrl_s;
   ctrl_t      ctrl_r;
   logic       set_halt_s;
   logic       sp_inc_s;
   logic       sp_dec_s;
   logic       flag_we_s;
   logic [1:0] flags_r;
   logic       halted_r;
   logic [2:0] dst_s;
   logic [2:0] src_s;
   logic       unused_inputs_s;

   assign dst_s           = instruction[5:3];
   assign src_s           = instruction[2:0];
   assign unused_inputs_s = ^{opcode, instruction[7:6]};

   // state decode; a halted core issues nothing and leaves SP and flags alone
   always_comb begin
      ctrl_s     = CTRL_IDLE;
      set_halt_s = 1'b0;
      sp_inc_s   = 1'b0;
      sp_dec_s   = 1'b0;
      flag_we_s  = 1'b0;
      if (halted_r) begin
         ctrl_s = CTRL_IDLE;
      end else begin
         case (state)
            STATE_NEXT: ctrl_s = CTRL_IDLE;
            STATE_FETCH_PC: begin
               ctrl_s.addr_sel = ADDR_PC;
               ctrl_s.mem_rd   = 1'b1;
               ctrl_s.pc_inc   = 1'b1;
            end
            STATE_FETCH_INST: begin
               ctrl_s.ir_load  = 1'b1;
               ctrl_s.tmp_load = 1'b1;
            end
            STATE_HALT: set_halt_s = 1'b1;
            STATE_JUMP: ctrl_s.pc_load = jump_taken(src_s, flags_r);
            STATE_OUT: begin
               ctrl_s.io_wr   = 1'b1;
               ctrl_s.reg_sel = dst_s;
            end
            STATE_IN: begin
               ctrl_s.io_rd   = 1'b1;
               ctrl_s.reg_we  = 1'b1;
               ctrl_s.reg_sel = dst_s;
            end
            STATE_SET_ADDR: ctrl_s.addr_sel = ADDR_TMP;
            STATE_ALU_EXEC: begin
               ctrl_s.alu_en = 1'b1;
               ctrl_s.alu_op = dst_s;
               flag_we_s     = 1'b1;
            end
            STATE_ALU_OUT: begin
               ctrl_s.reg_we  = 1'b1;
               ctrl_s.reg_sel = 3'd0;
            end
            STATE_MOV_FETCH: begin
               ctrl_s.reg_sel = src_s;
               if (src_s == MEM_REG) begin
                  ctrl_s.addr_sel = ADDR_TMP;
                  ctrl_s.mem_rd   = 1'b1;
               end else begin
                  ctrl_s.addr_sel = ADDR_PC;
               end
            end
            STATE_MOV_LOAD: ctrl_s.tmp_load = 1'b1;
            STATE_MOV_STORE: begin
               ctrl_s.reg_sel = dst_s;
               if (dst_s == MEM_REG) begin
                  ctrl_s.mem_wr = 1'b1;
               end else begin
                  ctrl_s.reg_we = 1'b1;
               end
            end
            STATE_FETCH_SP: ctrl_s.addr_sel = ADDR_SP;
            STATE_REG_STORE: begin
               ctrl_s.mem_wr  = 1'b1;
               ctrl_s.reg_sel = src_s;
               sp_dec_s       = 1'b1;
            end
            STATE_PC_STORE: begin
               ctrl_s.mem_wr    = 1'b1;
               ctrl_s.pc_to_bus = 1'b1;
               sp_dec_s         = 1'b1;
            end
            STATE_TMP_JUMP: ctrl_s.pc_load = 1'b1;
            STATE_INC_SP:   sp_inc_s = 1'b1;
            STATE_RET: begin
               ctrl_s.mem_rd  = 1'b1;
               ctrl_s.pc_load = 1'b1;
            end
            STATE_SET_REG: begin
               ctrl_s.reg_we  = 1'b1;
               ctrl_s.reg_sel = dst_s;
            end
            default: ctrl_s.bad_state = 1'b1;
         endcase
      end
   end

   // output register bank, flags and halt latch
   always_ff @(posedge clk or posedge reset_cycle) begin
      if (reset_cycle) begin
         ctrl_r   <= CTRL_IDLE;
         flags_r  <= 2'b00;
         halted_r <= 1'b0;
      end else begin
         ctrl_r   <= ctrl_s;
         flags_r  <= flag_we_s ? {alu_c, alu_z} : flags_r;
         halted_r <= halted_r | set_halt_s;
      end
   end

   cpu_sp_reg #(
      .SP_RESET (SP_RESET)
   ) u_sp (
      .clk         (clk),
      .reset_cycle (reset_cycle),
      .inc         (sp_inc_s),
      .dec         (sp_dec_s),
      .freeze      (halted_r),
      .sp          (sp)
   );

   assign addr_sel  = ctrl_r.addr_sel;
   assign mem_rd    = ctrl_r.mem_rd;
   assign mem_wr    = ctrl_r.mem_wr;
   assign io_rd     = ctrl_r.io_rd;
   assign io_wr     = ctrl_r.io_wr;
   assign pc_inc    = ctrl_r.pc_inc;
   assign pc_load   = ctrl_r.pc_load;
   assign ir_load   = ctrl_r.ir_load;
   assign tmp_load  = ctrl_r.tmp_load;
   assign reg_we    = ctrl_r.reg_we;
   assign reg_sel   = ctrl_r.reg_sel;
   assign pc_to_bus = ctrl_r.pc_to_bus;
   assign alu_en    = ctrl_r.alu_en;
   assign alu_op    = ctrl_r.alu_op;
   assign bad_state = ctrl_r.bad_state;
   assign flags     = flags_r;
   assign halted    = halted_r;

endmodule

// File: doc/cpu_ctrl_exec.md
# cpu_ctrl_exec

Execution side of the CPU control path. It consumes the `state`/`opcode`/`instruction` stream produced by the cycle sequencer every clock and turns it into registered datapath strobes: bus/address select, memory and I/O read/write, register-file write, ALU enable, PC and IR load. It also owns the stack pointer, the Z/C flag register used by conditional jumps, and the halt latch. It sits between the sequencer and the datapath (PC, register file, ALU, memory, I/O).

## Interface
Parameters:
- `SP_RESET`, 8'hFF: stack pointer value after reset; the stack grows downward.
- `MEM_REG`, 3'd7: register-field code that selects memory (M) instead of a register.

Ports:
- `clk`  in  1  clock.
- `reset_cycle`  in  1  asynchronous, active-high reset.
- `state`  in  8  state code from the sequencer.
- `opcode`  in  8  decoded opcode.
- `instruction`  in  8  raw instruction byte: [5:3] dst/ALU op, [2:0] src/jump condition.
- `alu_z`, `alu_c`  in  1 each  ALU zero and carry, valid combinationally in ALU_EXEC.
- `addr_sel`  out  2  address mux: 0=PC, 1=SP, 2=operand (TMP).
- `mem_rd`, `mem_wr`, `io_rd`, `io_wr`  out  1 each  memory and I/O strobes.
- `pc_inc`, `pc_load`, `ir_load`, `tmp_load`  out  1 each  PC, IR and TMP controls.
- `reg_we`  out  1  register-file write enable.
- `reg_sel`  out  3  register index for the read or write.
- `pc_to_bus`  out  1  drives PC onto the data bus.
- `alu_en`  out  1  ALU enable.
- `alu_op`  out  3  ALU operation.
- `sp`  out  8  current stack pointer.
- `flags`  out  2  {C,Z}.
- `halted`  out  1  halt latch.
- `bad_state`  out  1  one-cycle pulse on an unrecognised state code.

## Operation
- Decode the state codes listed below. Any other code raises `bad_state` for one cycle, drives all strobes to 0, and leaves SP and flags unchanged.
- NEXT 00: all strobes 0.
- FETCH_PC 01: `addr_sel`=0, `mem_rd`, `pc_inc`.
- FETCH_INST 02: `ir_load`, `tmp_load`. TMP captures the fetched operand/target.
- HALT 03: set `halted`.
- JUMP 04: condition = `instruction[2:0]`: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, others never. `pc_load`=condition.
- OUT 05: `io_wr`; `reg_sel`=[5:3].
- IN 12: `io_rd`, `reg_we`; `reg_sel`=[5:3].
- SET_ADDR 11: `addr_sel`=2.
- ALU_EXEC 07: `alu_en`; `alu_op`=[5:3]; latch `flags`<={alu_c,alu_z}. CMP updates flags only.
- ALU_OUT 06: `reg_we`; `reg_sel`=3'd0 (accumulator).
- MOV_FETCH 09: `reg_sel`=[2:0]. If src=`MEM_REG`: `addr_sel`=2, `mem_rd`.
- MOV_LOAD 0A: `tmp_load`.
- MOV_STORE 08: `reg_sel`=[5:3]. If dst=`MEM_REG`: `mem_wr`; else `reg_we`.
- FETCH_SP 0C: `addr_sel`=1.
- REG_STORE 13: `mem_wr`, `reg_sel`=[2:0]; SP decrements at end of cycle.
- PC_STORE 0D: `mem_wr`, `pc_to_bus`; SP decrements.
- TMP_JUMP 0E: `pc_load` from TMP.
- INC_SP 10: SP increments.
- RET 0F: `mem_rd`, `pc_load`.
- SET_REG 14: `reg_we`, `reg_sel`=[5:3] (LDI and POP).
- SP arithmetic is 8-bit modulo 256: FF+1→00, 00−1→FF. There is no overflow flag.
- While `halted`=1, all strobes are forced to 0 and SP and flags are frozen. Only `reset_cycle` clears `halted`.

## Timing
- Every strobe is registered: state S sampled at edge n produces its strobes during cycle n+1. Latency is 1 clock. Each strobe asserts for exactly one cycle per state occurrence.
- SP and flags update on the same edge that registers the strobes. `sp` reflects the new value from cycle n+1 onward.
- Reset values: all strobes 0, `addr_sel`=0, `reg_sel`=0, `alu_op`=0, `sp`=`SP_RESET`, `flags`=0, `halted`=0, `bad_state`=0.
- Reset is asynchronous and may arrive mid-instruction. Outputs go to reset values immediately, and any partially executed push or call is discarded.
- HALT sampled at edge n: `halted`=1 from cycle n+1. A HALT in the same cycle as a state that would write SP leaves SP unchanged.
- JUMP uses the flags registered before the edge, so an ALU_EXEC immediately preceding JUMP is visible to it.

## Structure
- Shared package `cpu_pkg` holds the STATE_* and OP_* localparams, the jump-condition codes and the `addr_sel` encodings. The sequencer and this block both import it.
- One sub-module, `cpu_sp_reg`: the 8-bit stack pointer with `inc`, `dec` and `freeze` inputs.
- The rest is a single `always_comb` decode followed by an output register bank.

## Test plan
- Reset → all strobes 0, `sp`=FF, `flags`=0. Then FETCH_PC → next cycle `mem_rd`=1, `pc_inc`=1, `addr_sel`=0.
- PUSH sequence FETCH_SP, REG_STORE with instruction 8'h23 → `mem_wr` with `reg_sel`=3, `sp` FF→FE. A following POP sequence (INC_SP) → `sp` back to FF.
- ALU_EXEC with `alu_z`=1, `alu_c`=0, then JUMP with [2:0]=001 → `pc_load`=1. Repeat with [2:0]=010 → `pc_load`=0.
- `sp`=00 followed by PC_STORE → `sp`=FF (wrap). `sp`=FF followed by INC_SP → 00.
- HALT → `halted`=1. Subsequent FETCH_PC/PC_STORE → strobes stay 0, `sp` unchanged. Asserting `reset_cycle` → `halted`=0.
- State 8'h0B → `bad_state` pulses for one cycle with all strobes 0. Asserting `reset_cycle` mid-CALL at PC_STORE → immediate reset values, no `mem_wr`.
